l3_req_arbiter: RTL and testbench
=================================

Name: l3_req_arbiter

Overview:
- Upstream front-end of each L3 slice.
- Accepts read/write requests from NUM_PORTS L2 caches and picks one by round-robin arbitration.
- Issues the winner to the slice as a single-cycle valid/ready pulse and captures the slice's one-beat response.
- Returns the response to the originating L2 with a valid/ready handshake.
- One transaction in flight at a time.

Parameters:
- NUM_PORTS, 4, number of L2 requesters; legal range 2..8.
- GID_W, $clog2(NUM_PORTS), width of grant index.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- l2_req_valid_i  in  NUM_PORTS  per-port request valid.
- l2_req_ready_o  out  NUM_PORTS  per-port request accept, one-hot or zero.
- l2_req_addr_i  in  NUM_PORTS*64  flattened addresses; port p at [p*64+:64].
- l2_req_write_i  in  NUM_PORTS  1=write, 0=read.
- l2_req_wdata_i  in  NUM_PORTS*64  flattened write data.
- l2_resp_valid_o  out  NUM_PORTS  per-port response valid, one-hot or zero.
- l2_resp_ready_i  in  NUM_PORTS  per-port response ready.
- l2_resp_rdata_o  out  64  shared response data bus.
- slc_req_valid_o  out  1  request valid to slice.
- slc_req_addr_o  out  64  address to slice.
- slc_req_write_o  out  1  write flag to slice.
- slc_req_wdata_o  out  64  write data to slice.
- slc_resp_ready_o  out  1  slice accept qualifier; slice samples a request only when valid and this are both high.
- slc_resp_valid_i  in  1  slice response pulse.
- slc_resp_rdata_i  in  64  slice response data.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: all outputs 0; state=IDLE; rr_ptr=0; grant id=0; latched addr/wdata/write/rdata=0.
- Reset asserted mid-transaction: the in-flight request is dropped and no response is ever returned for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.

IDLE:
- Combinationally select the first port with valid=1, searching rr_ptr, rr_ptr+1, … modulo NUM_PORTS.
- l2_req_ready_o[g]=1 for the selected port only; all others 0.
- On the clock edge: latch addr, write and wdata of port g; latch gid=g; go to ISSUE.
- No valid requests: stay in IDLE with all ready bits 0.

ISSUE (exactly 1 cycle):
- slc_req_valid_o=1 and slc_resp_ready_o=1.
- slc_req_addr_o, slc_req_write_o and slc_req_wdata_o driven from the latched registers.
- Go to WAIT.

WAIT:
- slc_req_valid_o=0 and slc_resp_ready_o=0; the latched payload stays on the slc_req_* buses.
- On slc_resp_valid_i=1: latch slc_resp_rdata_i and go to RESP.
- Without it, remain in WAIT indefinitely (no timeout).

RESP:
- l2_resp_valid_o[gid]=1 and l2_resp_rdata_o=latched rdata, both held stable until l2_resp_ready_i[gid]=1.
- On that edge: rr_ptr=(gid+1) mod NUM_PORTS, go to IDLE.
- Writes also return a response; rdata passes through as-is (slice returns 0 for writes).

Latency and throughput:
- Accept at cycle 0, slice sampled at cycle 1, slice response at cycle 2, l2_resp_valid_o high from cycle 3.
- Minimum 4 cycles per transaction.
- A new request is accepted no earlier than the cycle after the response handshake.

Interface rules:
- Requesters hold valid and payload stable until ready.
- Any slc_resp_valid_i outside WAIT is ignored.
- l2_resp_rdata_o is 0 whenever no l2_resp_valid_o bit is set.
- Fairness: a continuously requesting port waits at most NUM_PORTS-1 grants.
- Wrap-around: from rr_ptr=NUM_PORTS-1, the search continues at port 0.

Test Plan:
- Single read: port 2 reads addr 0x40 while slice returns 0xDEAD_BEEF -> ready[2] at cycle 0; slc_req_valid_o high at cycle 1 with addr 0x40, write=0; resp_valid[2] at cycle 3 with rdata 0xDEAD_BEEF.
- Write then read: port 0 writes 0x1234 to 0x80, then reads 0x80 through a behavioural slice model -> write response rdata 0; read returns 0x1234.
- Round-robin: all 4 ports valid continuously -> grant order 0,1,2,3,0; no port granted twice before all others are granted once.
- Response backpressure: hold l2_resp_ready_i[1]=0 for 5 cycles -> resp_valid[1] and rdata stable for all 5 cycles; no new ready until 1 cycle after the handshake.
- Delayed slice: slc_resp_valid_i arrives 6 cycles after ISSUE -> FSM stays in WAIT, busy_o=1, then RESP with the correct data; a stray slc_resp_valid_i pulse in IDLE produces no response.
- Reset mid-operation: assert rst_n=0 during WAIT -> all outputs 0 and rr_ptr=0; after release, port 0 is granted first and no response is delivered for the dropped request.

Source files
------------

// File: rtl/l3_req_arbiter.sv
// L3 slice request front-end: round-robin pick among NUM_PORTS L2 requesters,
// single-cycle issue to the slice, wait for its one-beat response, then hand
// the response back to the originating L2. One transaction in flight at a time.
module l3_req_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int GID_W     = $clog2(NUM_PORTS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_PORTS-1:0]    l2_req_valid_i,
    output logic [NUM_PORTS-1:0]    l2_req_ready_o,
    input  logic [NUM_PORTS*64-1:0] l2_req_addr_i,
    input  logic [NUM_PORTS-1:0]    l2_req_write_i,
    input  logic [NUM_PORTS*64-1:0] l2_req_wdata_i,
    output logic [NUM_PORTS-1:0]    l2_resp_valid_o,
    input  logic [NUM_PORTS-1:0]    l2_resp_ready_i,
    output logic [63:0]             l2_resp_rdata_o,
    output logic                    slc_req_valid_o,
    output logic [63:0]             slc_req_addr_o,
    output logic                    slc_req_write_o,
    output logic [63:0]             slc_req_wdata_o,
    output logic                    slc_resp_ready_o,
    input  logic                    slc_resp_valid_i,
    input  logic [63:0]             slc_resp_rdata_i,
    output logic                    busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [GID_W-1:0] gid_q, gid_d;
    logic [63:0]      addr_q, addr_d;
    logic             write_q, write_d;
    logic [63:0]      wdata_q, wdata_d;
    logic [63:0]      rdata_q, rdata_d;

    logic             sel_found;
    logic [GID_W-1:0] sel_idx;
    logic [GID_W:0]   cand;

    // Round-robin search: first valid port starting at rr_ptr, wrapping modulo NUM_PORTS.
    always_comb begin
        // NOTE: every variable driven here gets a default first, otherwise paths
        // that skip an assignment infer a latch.
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = {1'b0, rr_ptr_q} + (GID_W+1)'(i);
            if (cand >= (GID_W+1)'(NUM_PORTS)) begin
                cand = cand - (GID_W+1)'(NUM_PORTS);
            end
            if (!sel_found && l2_req_valid_i[cand[GID_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[GID_W-1:0];
            end
        end
    end

    // Next-state and handshake outputs for the IDLE/ISSUE/WAIT/RESP sequence.
    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        gid_d            = gid_q;
        addr_d           = addr_q;
        write_d          = write_q;
        wdata_d          = wdata_q;
        rdata_d          = rdata_q;
        l2_req_ready_o   = '0;
        l2_resp_valid_o  = '0;
        l2_resp_rdata_o  = '0;
        slc_req_valid_o  = 1'b0;
        slc_resp_ready_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    l2_req_ready_o[sel_idx] = 1'b1;
                    addr_d  = l2_req_addr_i[int'(sel_idx)*64 +: 64];
                    write_d = l2_req_write_i[sel_idx];
                    wdata_d = l2_req_wdata_i[int'(sel_idx)*64 +: 64];
                    gid_d   = sel_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                slc_req_valid_o  = 1'b1;
                slc_resp_ready_o = 1'b1;
                state_d          = WAIT;
            end
            WAIT: begin
                // Slice responses arriving in any other state are ignored.
                if (slc_resp_valid_i) begin
                    rdata_d = slc_resp_rdata_i;
                    state_d = RESP;
                end
            end
            RESP: begin
                l2_resp_valid_o[gid_q] = 1'b1;
                l2_resp_rdata_o        = rdata_q;
                if (l2_resp_ready_i[gid_q]) begin
                    // Priority moves to the port just after the one served.
                    rr_ptr_d = (gid_q == GID_W'(NUM_PORTS-1)) ? '0 : gid_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched transaction registers; reset drops any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gid_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gid_q    <= gid_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    assign slc_req_addr_o  = addr_q;
    assign slc_req_write_o = write_q;
    assign slc_req_wdata_o = wdata_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_l3_req_arbiter.sv
// Directed self-checking bench for l3_req_arbiter with a behavioural slice memory.
module tb_l3_req_arbiter;

    localparam int NP = 4;

    logic              clk;
    logic              rst_n;
    logic [NP-1:0]     req_valid;
    logic [NP-1:0]     req_ready;
    logic [NP*64-1:0]  req_addr;
    logic [NP-1:0]     req_write;
    logic [NP*64-1:0]  req_wdata;
    logic [NP-1:0]     resp_valid;
    logic [NP-1:0]     resp_ready;
    logic [63:0]       resp_rdata;
    logic              slc_req_valid;
    logic [63:0]       slc_req_addr;
    logic              slc_req_write;
    logic [63:0]       slc_req_wdata;
    logic              slc_resp_ready;
    logic              slc_resp_valid;
    logic [63:0]       slc_resp_rdata;
    logic              busy;

    int total = 0;
    int bad   = 0;

    // Behavioural slice storage: unwritten addresses read as 0.
    logic [63:0] mem [logic [63:0]];

    l3_req_arbiter #(.NUM_PORTS(NP)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .l2_req_valid_i   (req_valid),
        .l2_req_ready_o   (req_ready),
        .l2_req_addr_i    (req_addr),
        .l2_req_write_i   (req_write),
        .l2_req_wdata_i   (req_wdata),
        .l2_resp_valid_o  (resp_valid),
        .l2_resp_ready_i  (resp_ready),
        .l2_resp_rdata_o  (resp_rdata),
        .slc_req_valid_o  (slc_req_valid),
        .slc_req_addr_o   (slc_req_addr),
        .slc_req_write_o  (slc_req_write),
        .slc_req_wdata_o  (slc_req_wdata),
        .slc_resp_ready_o (slc_resp_ready),
        .slc_resp_valid_i (slc_resp_valid),
        .slc_resp_rdata_i (slc_resp_rdata),
        .busy_o           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [63:0] a, input logic w, input logic [63:0] wd);
        req_valid[p]        = 1'b1;
        req_addr[p*64 +: 64]  = a;
        req_write[p]        = w;
        req_wdata[p*64 +: 64] = wd;
    endtask

    // Runs one full transaction for whichever port the DUT grants, acting as the
    // slice (memory model) and the requesting L2, checking each phase on the way.
    task automatic serve(input bit keep_valid, input int delay, input int stall,
                         output int gport, output logic [63:0] iss_addr,
                         output logic iss_write, output logic [63:0] iss_wdata,
                         output logic [63:0] rdata_seen);
        int            n;
        logic [63:0]   exp;
        logic [NP-1:0] gmask;
        gport = -1; iss_addr = '0; iss_write = 1'b0; iss_wdata = '0; rdata_seen = '0;
        #1;
        n = 0;
        while (req_ready == '0 && n < 20) begin
            step();
            #1;
            n++;
        end
        total++;
        if (!$onehot(req_ready)) begin
            bad++;
            $display("FAIL grant_onehot: ready=%b, want exactly one bit set", req_ready);
            return;
        end
        for (int i = 0; i < NP; i++) if (req_ready[i]) gport = i;
        gmask = req_ready;

        step();
        if (!keep_valid) req_valid[gport] = 1'b0;
        #1;
        total++;
        if ({slc_req_valid, slc_resp_ready, busy, req_ready} !== {3'b111, 4'b0000}) begin
            bad++;
            $display("FAIL issue_phase: valid/ready/busy/l2ready=%b, want 1110000",
                     {slc_req_valid, slc_resp_ready, busy, req_ready});
        end
        iss_addr  = slc_req_addr;
        iss_write = slc_req_write;
        iss_wdata = slc_req_wdata;
        if (iss_write) begin
            mem[iss_addr] = iss_wdata;
            exp = 64'h0;
        end else begin
            exp = mem.exists(iss_addr) ? mem[iss_addr] : 64'h0;
        end

        step();
        #1;
        total++;
        if ({slc_req_valid, slc_resp_ready, busy} !== 3'b001 || slc_req_addr !== iss_addr) begin
            bad++;
            $display("FAIL wait_phase: valid/ready/busy=%b addr=%h, want 001 addr=%h",
                     {slc_req_valid, slc_resp_ready, busy}, slc_req_addr, iss_addr);
        end
        for (int d = 0; d < delay; d++) begin
            step();
            #1;
            total++;
            if ({busy, slc_req_valid, resp_valid} !== {1'b1, 1'b0, 4'b0000}) begin
                bad++;
                $display("FAIL wait_hold[%0d]: busy/slcvalid/respvalid=%b, want 100000",
                         d, {busy, slc_req_valid, resp_valid});
            end
        end

        slc_resp_valid = 1'b1;
        slc_resp_rdata = exp;
        step();
        slc_resp_valid = 1'b0;
        slc_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int s = 0; s <= stall; s++) begin
            if (s == stall) resp_ready[gport] = 1'b1;
            #1;
            total++;
            if (resp_valid !== gmask || resp_rdata !== exp || req_ready !== '0) begin
                bad++;
                $display("FAIL resp_hold[%0d]: respvalid=%b rdata=%h l2ready=%b, want %b %h 0000",
                         s, resp_valid, resp_rdata, req_ready, gmask, exp);
            end
            rdata_seen = resp_rdata;
            step();
        end
        resp_ready[gport] = 1'b0;
        #1;
        total++;
        if ({resp_valid, resp_rdata, busy} !== '0) begin
            bad++;
            $display("FAIL resp_release: respvalid=%b rdata=%h busy=%b, want all 0",
                     resp_valid, resp_rdata, busy);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = '0; resp_ready = '0; slc_resp_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        #1;
    endtask

    task automatic test_reset();
        step();
        #1;
        total++;
        if ({req_ready, resp_valid, resp_rdata, slc_req_valid, slc_req_addr, slc_req_write,
             slc_req_wdata, slc_resp_ready, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: some output nonzero while rst_n=0 (busy=%b slcvalid=%b)",
                     busy, slc_req_valid);
        end
        rst_n = 1'b1;
        step();
        #1;
        total++;
        if ({req_ready, resp_valid, slc_req_valid, slc_resp_ready, busy} !== '0) begin
            bad++;
            $display("FAIL reset_idle: ready=%b respvalid=%b busy=%b, want all 0",
                     req_ready, resp_valid, busy);
        end
    endtask

    task automatic test_single_read();
        int g; logic [63:0] a, wd, r; logic w;
        mem[64'h40] = 64'hDEAD_BEEF;
        set_port(2, 64'h40, 1'b0, 64'h0);
        serve(1'b0, 0, 0, g, a, w, wd, r);
        total++;
        if (g !== 2 || a !== 64'h40 || w !== 1'b0 || r !== 64'hDEAD_BEEF) begin
            bad++;
            $display("FAIL single_read: port=%0d addr=%h wr=%b rdata=%h, want 2 40 0 deadbeef",
                     g, a, w, r);
        end
    endtask

    task automatic test_write_read();
        int g; logic [63:0] a, wd, r; logic w;
        set_port(0, 64'h80, 1'b1, 64'h1234);
        serve(1'b0, 0, 0, g, a, w, wd, r);
        total++;
        if (g !== 0 || a !== 64'h80 || w !== 1'b1 || wd !== 64'h1234 || r !== 64'h0) begin
            bad++;
            $display("FAIL write_resp: port=%0d addr=%h wr=%b wdata=%h rdata=%h, want 0 80 1 1234 0",
                     g, a, w, wd, r);
        end
        set_port(0, 64'h80, 1'b0, 64'h5A5A);
        serve(1'b0, 0, 0, g, a, w, wd, r);
        total++;
        if (g !== 0 || w !== 1'b0 || r !== 64'h1234) begin
            bad++;
            $display("FAIL read_after_write: port=%0d wr=%b rdata=%h, want 0 0 1234", g, w, r);
        end
    endtask

    task automatic test_round_robin();
        int g; logic [63:0] a, wd, r; logic w;
        int exp_order [5] = '{0, 1, 2, 3, 0};
        apply_reset();
        for (int p = 0; p < NP; p++) begin
            mem[64'h1000 + p*256] = 64'hA0 + p;
            set_port(p, 64'h1000 + p*256, 1'b0, 64'h0);
        end
        for (int k = 0; k < 5; k++) begin
            serve(1'b1, 0, 0, g, a, w, wd, r);
            total++;
            if (g !== exp_order[k] || a !== 64'h1000 + exp_order[k]*256 || r !== 64'hA0 + exp_order[k]) begin
                bad++;
                $display("FAIL rr_order[%0d]: port=%0d addr=%h rdata=%h, want port %0d",
                         k, g, a, r, exp_order[k]);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_back_to_back();
        int g; logic [63:0] a, wd, r; logic w;
        mem[64'h200] = 64'h5555;
        mem[64'h300] = 64'h7777;
        set_port(1, 64'h200, 1'b0, 64'h0);
        set_port(3, 64'h300, 1'b0, 64'h0);
        serve(1'b0, 0, 5, g, a, w, wd, r);
        total++;
        if (g !== 1 || r !== 64'h5555) begin
            bad++;
            $display("FAIL backpressure: port=%0d rdata=%h, want 1 5555", g, r);
        end
        total++;
        if (req_ready !== 4'b1000) begin
            bad++;
            $display("FAIL next_accept: ready=%b one cycle after handshake, want 1000", req_ready);
        end
        serve(1'b0, 0, 0, g, a, w, wd, r);
        total++;
        if (g !== 3 || r !== 64'h7777) begin
            bad++;
            $display("FAIL second_port: port=%0d rdata=%h, want 3 7777", g, r);
        end
    endtask

    task automatic test_delayed_slice();
        int g; logic [63:0] a, wd, r; logic w;
        slc_resp_valid = 1'b1;
        slc_resp_rdata = 64'hBAD;
        step();
        slc_resp_valid = 1'b0;
        #1;
        total++;
        if ({resp_valid, busy} !== 5'b0) begin
            bad++;
            $display("FAIL stray_pulse: respvalid=%b busy=%b, want 0000 0", resp_valid, busy);
        end
        mem[64'h400] = 64'hCAFE;
        set_port(2, 64'h400, 1'b0, 64'h0);
        serve(1'b0, 5, 0, g, a, w, wd, r);
        total++;
        if (g !== 2 || r !== 64'hCAFE) begin
            bad++;
            $display("FAIL delayed_slice: port=%0d rdata=%h, want 2 cafe", g, r);
        end
    endtask

    task automatic test_reset_mid();
        int g; logic [63:0] a, wd, r; logic w;
        mem[64'h500] = 64'h99;
        set_port(2, 64'h500, 1'b0, 64'h0);
        #1;
        step();
        req_valid[2] = 1'b0;
        step();
        #1;
        total++;
        if ({busy, slc_req_valid} !== 2'b10) begin
            bad++;
            $display("FAIL mid_wait: busy/slcvalid=%b, want 10", {busy, slc_req_valid});
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({req_ready, resp_valid, resp_rdata, slc_req_valid, slc_req_addr, slc_req_write,
             slc_req_wdata, slc_resp_ready, busy} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: busy=%b addr=%h, want all outputs 0", busy, slc_req_addr);
        end
        step();
        rst_n = 1'b1;
        slc_resp_valid = 1'b1;
        slc_resp_rdata = 64'h99;
        step();
        slc_resp_valid = 1'b0;
        #1;
        total++;
        if ({resp_valid, busy} !== 5'b0) begin
            bad++;
            $display("FAIL dropped_resp: respvalid=%b busy=%b, want 0000 0", resp_valid, busy);
        end
        for (int p = 0; p < NP; p++) set_port(p, 64'h1000 + p*256, 1'b0, 64'h0);
        serve(1'b0, 0, 0, g, a, w, wd, r);
        total++;
        if (g !== 0 || r !== 64'hA0) begin
            bad++;
            $display("FAIL post_reset_grant: port=%0d rdata=%h, want 0 a0", g, r);
        end
        req_valid = '0;
    endtask

    initial begin
        rst_n          = 1'b0;
        req_valid      = '0;
        req_addr       = '0;
        req_write      = '0;
        req_wdata      = '0;
        resp_ready     = '0;
        slc_resp_valid = 1'b0;
        slc_resp_rdata = '0;

        test_reset();
        test_single_read();
        test_write_read();
        test_round_robin();
        test_back_to_back();
        test_delayed_slice();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
